mem_bridge: RTL and testbench
=============================

// Module: mem_bridge
// PURPOSE
//  Sits between the core memory port and the system bus (downstream of the core).
//  - Converts the core's level-held request into one valid/ready request beat plus one response beat.
//    Core side: mem_read/mem_write held until mem_resp.
//  - Single outstanding transaction.
//  - Registers the request and response paths.
//  - Reports bus errors; optionally reports watchdog timeouts.
// PARAMETERS
//  AW              32            address width
//  DW              32            data width; byte-enable width BW = DW/8
//  TIMEOUT_CYCLES  256           watchdog limit in WAIT_RSP (used only with MEM_BRIDGE_TIMEOUT_EN)
//  ERR_RDATA       32'hDEADBEEF  core_rdata value returned on error/timeout
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  rst            in   1   synchronous reset, active-high
//  core_addr      in   AW  word-aligned address (core drives [1:0]=0)
//  core_wdata     in   DW  store data, already lane-aligned
//  core_be        in   BW  byte enables
//  core_read      in   1   read request, held until core_resp
//  core_write     in   1   write request, held until core_resp
//  core_rdata     out  DW  read data, valid in core_resp cycle
//  core_resp      out  1   one-cycle completion pulse
//  bus_req_valid  out  1   request beat valid
//  bus_req_ready  in   1   slave accepts beat
//  bus_req_write  out  1   1=write, 0=read
//  bus_req_addr   out  AW  request address
//  bus_req_wdata  out  DW  write data
//  bus_req_be     out  BW  byte enables (all-ones for reads)
//  bus_rsp_valid  in   1   response beat
//  bus_rsp_rdata  in   DW  response read data
//  bus_rsp_err    in   1   response error, qualified by bus_rsp_valid
//  err_clr        in   1   clears sticky error state
//  err_flag       out  1   sticky: bus error (or timeout) seen
//  err_addr       out  AW  address of first error since clear
// BEHAVIOUR
//  Reset
//   - All outputs 0; state=IDLE; err_addr=0.
//   - Reset mid-transaction abandons it silently: no core_resp; a late bus_rsp_valid is ignored.
//  FSM states: IDLE, REQ, WAIT_RSP, RESP.
//   - IDLE: if core_read|core_write, capture addr/wdata/be/dir into regs, go to REQ.
//     - Both asserted: treated as write; err_flag set.
//   - REQ: bus_req_valid=1, driven from regs, stable until accepted.
//     - On bus_req_valid&bus_req_ready, go to WAIT_RSP.
//   - WAIT_RSP: on bus_rsp_valid, register data, go to RESP.
//     - Data registered: rsp_rdata for reads, 0 for writes, ERR_RDATA if err.
//   - RESP: core_resp=1 for exactly one cycle, go to IDLE.
//  bus_rsp_valid is ignored outside WAIT_RSP.
//  Back-to-back: a request held in the cycle after core_resp is a new transaction.
//  Minimum latency: request seen cycle 0, bus_req_valid cycle 1, rsp cycle 2, core_resp cycle 3.
//  Errors
//   - On bus_rsp_err: err_flag<=1; err_addr captured only if err_flag was 0.
//   - err_clr clears err_flag/err_addr.
//   - err_clr and a new error in the same cycle: the error wins (flag=1, new addr).
//  Core inputs are not sampled outside IDLE; changes mid-transaction have no effect.
// CONFIGURATION
//  MEM_BRIDGE_TIMEOUT_EN defined
//   - Counter cleared on entry to WAIT_RSP, increments each WAIT_RSP cycle.
//   - On reaching TIMEOUT_CYCLES with no rsp: go to RESP with core_rdata=ERR_RDATA, and set err_flag/err_addr.
//   - A rsp arriving later is ignored.
//   - A rsp in the same cycle as the timeout wins; no timeout error.
//  MEM_BRIDGE_TIMEOUT_EN undefined
//   - No counter; WAIT_RSP waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  1. Read 0x1000, ready=1, rsp 1 cycle later with rdata 0x00500093:
//     -> bus beat addr 0x1000 be 4'hF write=0; core_resp at cycle 3; core_rdata=0x00500093.
//  2. Write 0x2004 wdata 0xAABBCCDD be 4'b0100, ready low 5 cycles:
//     -> valid/addr/wdata stable all 5 cycles; exactly one beat; core_resp after rsp; core_rdata=0.
//  3. Read 0x3000 with rsp_err=1:
//     -> core_rdata=0xDEADBEEF, err_flag=1, err_addr=0x3000.
//     -> Second error at 0x4000 keeps err_addr=0x3000; err_clr zeroes both.
//  4. Back-to-back read/read held continuously:
//     -> two distinct bus beats, two one-cycle core_resp pulses, no extra beat.
//     -> Spurious rsp_valid while in IDLE: ignored.
//  5. rst asserted in WAIT_RSP, then late rsp_valid:
//     -> all outputs 0, no core_resp.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp:
//     -> core_resp at 8 WAIT_RSP cycles, rdata 0xDEADBEEF, err_flag=1.
//     -> Without the macro: still waiting at cycle 1000.

Source files
------------

// File: rtl/mem_bridge.sv
// mem_bridge: core memory port -> system bus valid/ready bridge.
//  - Turns the core's level-held read/write into one request beat and
//    one response beat; a single transaction is outstanding at a time.
//  - Request and response paths are registered. Minimum latency is
//    request seen in cycle 0 and core_resp in cycle 3.
//  - Bus errors set a sticky err_flag and record the first failing address.
//  - Optional watchdog on the response wait, enabled by defining
//    MEM_BRIDGE_TIMEOUT_EN. Without it, WAIT_RSP waits indefinitely.
module mem_bridge #(
  parameter int              AW             = 32,
  parameter int              DW             = 32,
  parameter int              TIMEOUT_CYCLES = 256,
  parameter logic [DW-1:0]   ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  // core side
  input  logic [AW-1:0]     core_addr,
  input  logic [DW-1:0]     core_wdata,
  input  logic [DW/8-1:0]   core_be,
  input  logic              core_read,
  input  logic              core_write,
  output logic [DW-1:0]     core_rdata,
  output logic              core_resp,
  // bus request channel
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [AW-1:0]     bus_req_addr,
  output logic [DW-1:0]     bus_req_wdata,
  output logic [DW/8-1:0]   bus_req_be,
  // bus response channel
  input  logic              bus_rsp_valid,
  input  logic [DW-1:0]     bus_rsp_rdata,
  input  logic              bus_rsp_err,
  // error reporting
  input  logic              err_clr,
  output logic              err_flag,
  output logic [AW-1:0]     err_addr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t          state;
  logic            timeout_hit;
  logic            err_evt;
  logic [AW-1:0]   err_evt_addr;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wd_cnt;

  // Watchdog: counts WAIT_RSP cycles and is held at zero in every other state,
  // so it always starts from zero when WAIT_RSP is entered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of block ordering.
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != WAIT_RSP) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Timeout fires on the last allowed WAIT_RSP cycle; a response in that same
  // cycle takes precedence.
  assign timeout_hit = (state == WAIT_RSP) && !bus_rsp_valid &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Error event decode: conflicting core request, bus error response, or timeout.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    err_evt      = 1'b0;
    err_evt_addr = bus_req_addr;
    if (state == IDLE && core_read && core_write) begin
      err_evt      = 1'b1;
      err_evt_addr = core_addr;
    end else if (state == WAIT_RSP && bus_rsp_valid && bus_rsp_err) begin
      err_evt      = 1'b1;
    end else if (timeout_hit) begin
      err_evt      = 1'b1;
    end
  end

  // Transaction FSM with registered bus request and core response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      core_rdata    <= '0;
      core_resp     <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_write <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_be    <= '0;
    end else begin
      core_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (core_read || core_write) begin
            // A simultaneous read and write is treated as a write.
            bus_req_write <= core_write;
            bus_req_addr  <= core_addr;
            bus_req_wdata <= core_write ? core_wdata : '0;
            bus_req_be    <= core_write ? core_be : '1;
            bus_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus_rsp_valid) begin
            if (bus_rsp_err) begin
              core_rdata <= ERR_RDATA;
            end else if (bus_req_write) begin
              core_rdata <= '0;
            end else begin
              core_rdata <= bus_rsp_rdata;
            end
            core_resp <= 1'b1;
            state     <= RESP;
          end else if (timeout_hit) begin
            core_rdata <= ERR_RDATA;
            core_resp  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flag and first-error address; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_evt) begin
      err_flag <= 1'b1;
      if (!err_flag || err_clr) begin
        err_addr <= err_evt_addr;
      end
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed testbench for mem_bridge with hand-computed expectations.
// Build with MEM_BRIDGE_TIMEOUT_EN defined to exercise the watchdog.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_be;
  logic        core_read;
  logic        core_write;
  logic [31:0] core_rdata;
  logic        core_resp;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic        err_clr;
  logic        err_flag;
  logic [31:0] err_addr;

  int vectors     = 0;
  int miscompares = 0;
  int beats       = 0;

  mem_bridge #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_be       (core_be),
    .core_read     (core_read),
    .core_write    (core_write),
    .core_rdata    (core_rdata),
    .core_resp     (core_resp),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_be    (bus_req_be),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .err_clr       (err_clr),
    .err_flag      (err_flag),
    .err_addr      (err_addr)
  );

  always #5 clk = ~clk;

  // Count accepted request beats.
  always @(posedge clk) begin
    if (bus_req_valid && bus_req_ready) beats <= beats + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency transaction: ready at once, response the cycle after acceptance.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] rsp_data, input logic rsp_e,
                        input logic clr_at_rsp,
                        output logic [31:0] rdata_seen, output logic resp_seen);
    core_addr     = addr;
    core_wdata    = wdata;
    core_be       = be;
    core_write    = wr;
    core_read     = !wr;
    bus_req_ready = 1'b1;
    tick();                       // REQ
    tick();                       // WAIT_RSP
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = rsp_data;
    bus_rsp_err   = rsp_e;
    err_clr       = clr_at_rsp;
    tick();                       // RESP
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    err_clr       = 1'b0;
    resp_seen     = core_resp;
    rdata_seen    = core_rdata;
    core_read     = 1'b0;
    core_write    = 1'b0;
    tick();                       // IDLE
  endtask

  initial begin
    logic [31:0] rd;
    logic        rs;
    int          b0;
    int          resp_cnt;

    rst = 1'b1; core_addr = '0; core_wdata = '0; core_be = '0;
    core_read = 1'b0; core_write = 1'b0; bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0; err_clr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", {31'd0, bus_req_valid}, 32'd0);
    check("rst_resp",  {31'd0, core_resp}, 32'd0);
    check("rst_flag",  {31'd0, err_flag}, 32'd0);
    check("rst_be",    {28'd0, bus_req_be}, 32'd0);
    rst = 1'b0;
    tick();

    // 1. Read 0x1000, minimum latency
    b0 = beats;
    core_addr = 32'h1000; core_be = 4'h0; core_read = 1'b1; bus_req_ready = 1'b1;
    tick();  // cycle 1
    check("t1_valid", {31'd0, bus_req_valid}, 32'd1);
    check("t1_addr",  bus_req_addr, 32'h1000);
    check("t1_be",    {28'd0, bus_req_be}, 32'hF);
    check("t1_write", {31'd0, bus_req_write}, 32'd0);
    tick();  // cycle 2
    check("t1_valid_drop", {31'd0, bus_req_valid}, 32'd0);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h00500093;
    tick();  // cycle 3
    check("t1_resp",  {31'd0, core_resp}, 32'd1);
    check("t1_rdata", core_rdata, 32'h00500093);
    bus_rsp_valid = 1'b0; core_read = 1'b0;
    tick();
    check("t1_resp_pulse", {31'd0, core_resp}, 32'd0);
    check("t1_beats", beats - b0, 32'd1);

    // 2. Write 0x2004 with ready held low for 5 cycles
    b0 = beats;
    core_addr = 32'h2004; core_wdata = 32'hAABBCCDD; core_be = 4'b0100; core_write = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", {31'd0, bus_req_valid}, 32'd1);
      check("t2_addr",  bus_req_addr, 32'h2004);
      check("t2_wdata", bus_req_wdata, 32'hAABBCCDD);
      tick();
    end
    check("t2_be",    {28'd0, bus_req_be}, 32'h4);
    check("t2_write", {31'd0, bus_req_write}, 32'd1);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    check("t2_valid_drop", {31'd0, bus_req_valid}, 32'd0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h12345678;
    tick();
    bus_rsp_valid = 1'b0; core_write = 1'b0;
    check("t2_resp",  {31'd0, core_resp}, 32'd1);
    check("t2_rdata", core_rdata, 32'd0);
    tick();
    check("t2_beats", beats - b0, 32'd1);

    // 3. Error handling
    do_txn(1'b0, 32'h3000, 32'd0, 4'h0, 32'h55555555, 1'b1, 1'b0, rd, rs);
    check("t3_resp",  {31'd0, rs}, 32'd1);
    check("t3_rdata", rd, 32'hDEADBEEF);
    check("t3_flag",  {31'd0, err_flag}, 32'd1);
    check("t3_addr",  err_addr, 32'h3000);
    do_txn(1'b1, 32'h4000, 32'h1, 4'hF, 32'd0, 1'b1, 1'b0, rd, rs);
    check("t3_addr_keep", err_addr, 32'h3000);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_clr_flag", {31'd0, err_flag}, 32'd0);
    check("t3_clr_addr", err_addr, 32'd0);
    do_txn(1'b0, 32'h5000, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0, rd, rs);
    check("t3_addr_5000", err_addr, 32'h5000);
    do_txn(1'b0, 32'h6000, 32'd0, 4'h0, 32'd0, 1'b1, 1'b1, rd, rs);
    check("t3_errwins_flag", {31'd0, err_flag}, 32'd1);
    check("t3_errwins_addr", err_addr, 32'h6000);

    // Read and write both asserted: treated as write, flags an error
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    core_addr = 32'h7000; core_wdata = 32'hCAFEF00D; core_be = 4'h3;
    core_read = 1'b1; core_write = 1'b1; bus_req_ready = 1'b1;
    tick();
    check("both_write", {31'd0, bus_req_write}, 32'd1);
    check("both_flag",  {31'd0, err_flag}, 32'd1);
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h99999999;
    tick();
    bus_rsp_valid = 1'b0; core_read = 1'b0; core_write = 1'b0;
    check("both_resp",  {31'd0, core_resp}, 32'd1);
    check("both_rdata", core_rdata, 32'd0);
    tick();

    // 4. Back-to-back reads, ready and rsp_valid held high throughout
    b0 = beats;
    core_addr = 32'h8000; core_read = 1'b1; bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h11110000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("t4_resp_c%0d", c), {31'd0, core_resp}, {31'd0, (c == 3 || c == 7)});
      check($sformatf("t4_valid_c%0d", c), {31'd0, bus_req_valid}, {31'd0, (c == 1 || c == 5)});
      if (c == 1) check("t4_addr0", bus_req_addr, 32'h8000);
      if (c == 5) check("t4_addr1", bus_req_addr, 32'h8004);
      if (c == 3 || c == 7) check($sformatf("t4_rdata_c%0d", c), core_rdata, 32'h11110000);
      if (c == 4) core_addr = 32'h8004;
      if (c == 7) core_read = 1'b0;
    end
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_resp || bus_req_valid) resp_cnt++;
    end
    check("t4_idle_rsp_ignored", resp_cnt, 32'd0);
    check("t4_beats", beats - b0, 32'd2);
    bus_rsp_valid = 1'b0; bus_req_ready = 1'b0;

    // 5. Reset in WAIT_RSP, then a late response
    core_addr = 32'hA000; core_read = 1'b1; bus_req_ready = 1'b1;
    tick(); tick();
    bus_req_ready = 1'b0; core_read = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h77777777;
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_rsp_valid = 1'b0;
      if (core_resp) resp_cnt++;
    end
    check("t5_no_resp", resp_cnt, 32'd0);
    check("t5_valid",   {31'd0, bus_req_valid}, 32'd0);
    check("t5_addr",    bus_req_addr, 32'd0);
    check("t5_rdata",   core_rdata, 32'd0);
    check("t5_flag",    {31'd0, err_flag}, 32'd0);
    check("t5_erraddr", err_addr, 32'd0);

    // 6. No response: watchdog (if built in) or indefinite wait
    core_addr = 32'h9000; core_read = 1'b1; bus_req_ready = 1'b1;
    tick(); tick();   // WAIT_RSP cycle 1
    bus_req_ready = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    resp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (core_resp) resp_cnt++;
      tick();
    end
    check("t6_early_resp", resp_cnt, 32'd0);
    tick();           // RESP after 8 WAIT_RSP cycles
    check("t6_resp",  {31'd0, core_resp}, 32'd1);
    check("t6_rdata", core_rdata, 32'hDEADBEEF);
    check("t6_flag",  {31'd0, err_flag}, 32'd1);
    check("t6_addr",  err_addr, 32'h9000);
    core_read = 1'b0; bus_rsp_valid = 1'b1;
    tick();
    bus_rsp_valid = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_resp) resp_cnt++;
    end
    check("t6_late_rsp_ignored", resp_cnt, 32'd0);
`else
    resp_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (core_resp) resp_cnt++;
    end
    check("t6_still_waiting", resp_cnt, 32'd0);
    check("t6_flag", {31'd0, err_flag}, 32'd0);
    core_read = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
